// File: rtl/id_ex_bypass_stage_pkg.sv
// id_ex_bypass_stage_pkg
//   Shared widths, bypass select codes and the ID/EX register layout for the
//   ID/EX pipeline stage of the five-stage core.
package id_ex_bypass_stage_pkg;

    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;
    localparam int ADDR_SIZE   = 32;
    localparam int CTRL_W      = 16;
    localparam int NUM_OPS     = 2;   // rs1, rs2

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Everything captured from decode into the EX slot.
    typedef struct packed {
        logic                   valid;
        logic [ADDR_SIZE-1:0]   pc;
        logic [RFIDX_WIDTH-1:0] rs1;
        logic [RFIDX_WIDTH-1:0] rs2;
        logic                   use_rs1;
        logic                   use_rs2;
        logic [RFIDX_WIDTH-1:0] rd;
        logic [XLEN-1:0]        rd1;
        logic [XLEN-1:0]        rd2;
        logic [XLEN-1:0]        imm;
        logic                   regwrite;
        logic                   memread;
        logic [CTRL_W-1:0]      ctrl;
    } id_ex_t;

    // A later-stage write matches a source only if the source is really read,
    // is not x0, and the producer actually writes a register.
    function automatic logic reg_hit(input logic                   use_i,
                                     input logic [RFIDX_WIDTH-1:0] rs,
                                     input logic                   we,
                                     input logic [RFIDX_WIDTH-1:0] rd);
        return use_i && (rs != '0) && we && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_bypass_stage_if.sv
// id_ex_bypass_stage_if
//   Decode-to-EX bundle. slave: the ID/EX stage (takes id_*, drives ex_*).
//   master: the decode side / observer (drives id_*, takes ex_*).
interface id_ex_bypass_stage_if;
    import id_ex_bypass_stage_pkg::*;

    logic                   id_valid;
    logic [ADDR_SIZE-1:0]   id_pc;
    logic [RFIDX_WIDTH-1:0] id_rs1, id_rs2;
    logic                   id_use_rs1, id_use_rs2;
    logic [RFIDX_WIDTH-1:0] id_rd;
    logic [XLEN-1:0]        id_rd1, id_rd2;
    logic [XLEN-1:0]        id_imm;
    logic                   id_regwrite, id_memread;
    logic [CTRL_W-1:0]      id_ctrl;

    logic                   ex_valid;
    logic [ADDR_SIZE-1:0]   ex_pc;
    logic [RFIDX_WIDTH-1:0] ex_rd;
    logic [XLEN-1:0]        ex_imm;
    logic [CTRL_W-1:0]      ex_ctrl;
    logic                   ex_regwrite, ex_memread;
    logic [XLEN-1:0]        ex_src1, ex_src2;
    logic [1:0]             ex_fwd1, ex_fwd2;

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rd1, id_rd2, id_imm, id_regwrite, id_memread, id_ctrl,
        output ex_valid, ex_pc, ex_rd, ex_imm, ex_ctrl, ex_regwrite, ex_memread,
               ex_src1, ex_src2, ex_fwd1, ex_fwd2
    );

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rd1, id_rd2, id_imm, id_regwrite, id_memread, id_ctrl,
        input  ex_valid, ex_pc, ex_rd, ex_imm, ex_ctrl, ex_regwrite, ex_memread,
               ex_src1, ex_src2, ex_fwd1, ex_fwd2
    );

endinterface

// File: rtl/id_ex_bypass_stage_bypass_mux.sv
// id_ex_bypass_stage_bypass_mux
//   One EX operand: picks EX/MEM result, MEM/WB writeback data or the captured
//   regfile value. MEM is the younger producer, so it wins a double match.
//   Ports: rs/use_rs/rf_data (captured source), mem_* / wb_* (producers),
//          sel (FWD_* code), data (operand to EX).
module id_ex_bypass_stage_bypass_mux
    import id_ex_bypass_stage_pkg::*;
(
    input  logic [RFIDX_WIDTH-1:0] rs,
    input  logic                   use_rs,
    input  logic [XLEN-1:0]        rf_data,
    input  logic                   mem_regwrite,
    input  logic [RFIDX_WIDTH-1:0] mem_rd,
    input  logic [XLEN-1:0]        mem_result,
    input  logic                   wb_regwrite,
    input  logic [RFIDX_WIDTH-1:0] wb_rd,
    input  logic [XLEN-1:0]        wb_wdata,
    output logic [1:0]             sel,
    output logic [XLEN-1:0]        data
);

    always_comb begin
        sel  = FWD_RF;
        data = rf_data;
        if (reg_hit(use_rs, rs, mem_regwrite, mem_rd)) begin
            sel  = FWD_MEM;
            data = mem_result;
        end else if (reg_hit(use_rs, rs, wb_regwrite, wb_rd)) begin
            sel  = FWD_WB;
            data = wb_wdata;
        end
    end

endmodule

// File: rtl/id_ex_bypass_stage.sv
// id_ex_bypass_stage
//   ID/EX pipeline register with operand bypass and load-use bubble insertion.
//   Ports: clk, rst (sync, active high); bus (id_* in, ex_* out);
//          mem_* / wb_* forwarding sources; hold (freeze), flush (kill EX);
//          load_use_stall (combinational, holds IF/ID and PC).
//   Writes older than MEM/WB are already in the negedge-write regfile, so only
//   two producers are bypassed.
module id_ex_bypass_stage
    import id_ex_bypass_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    id_ex_bypass_stage_if.slave    bus,
    input  logic                   mem_regwrite,
    input  logic [RFIDX_WIDTH-1:0] mem_rd,
    input  logic [XLEN-1:0]        mem_result,
    input  logic                   wb_regwrite,
    input  logic [RFIDX_WIDTH-1:0] wb_rd,
    input  logic [XLEN-1:0]        wb_wdata,
    input  logic                   hold,
    input  logic                   flush,
    output logic                   load_use_stall
);

    id_ex_t r, cap;

    always_comb begin
        cap          = '0;
        cap.valid    = bus.id_valid;
        cap.pc       = bus.id_pc;
        cap.rs1      = bus.id_rs1;
        cap.rs2      = bus.id_rs2;
        cap.use_rs1  = bus.id_use_rs1;
        cap.use_rs2  = bus.id_use_rs2;
        cap.rd       = bus.id_rd;
        cap.rd1      = bus.id_rd1;
        cap.rd2      = bus.id_rd2;
        cap.imm      = bus.id_imm;
        cap.regwrite = bus.id_regwrite & bus.id_valid;
        cap.memread  = bus.id_memread & bus.id_valid;
        cap.ctrl     = bus.id_ctrl;
    end

    // Load in EX whose result the decode instruction needs next cycle. A flush
    // kills the decode instruction, so no stall is needed then.
    always_comb begin
        load_use_stall = r.valid && r.memread && (r.rd != '0) && bus.id_valid &&
                         ((bus.id_use_rs1 && bus.id_rs1 == r.rd) ||
                          (bus.id_use_rs2 && bus.id_rs2 == r.rd)) && !flush;
    end

    // Bubble clears only the fields that have architectural side effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (flush) begin
            r.valid    <= 1'b0;
            r.regwrite <= 1'b0;
            r.memread  <= 1'b0;
        end else if (!hold) begin
            if (load_use_stall) begin
                r.valid    <= 1'b0;
                r.regwrite <= 1'b0;
                r.memread  <= 1'b0;
            end else begin
                r <= cap;
            end
        end
    end

    assign bus.ex_valid    = r.valid;
    assign bus.ex_pc       = r.pc;
    assign bus.ex_rd       = r.rd;
    assign bus.ex_imm      = r.imm;
    assign bus.ex_ctrl     = r.ctrl;
    assign bus.ex_regwrite = r.regwrite & r.valid;
    assign bus.ex_memread  = r.memread & r.valid;

    // Forwarding stays live during hold: the captured rd1/rd2 were correct at
    // capture, and newer producers are picked up as MEM/WB change.
    logic [NUM_OPS-1:0][RFIDX_WIDTH-1:0] op_rs;
    logic [NUM_OPS-1:0]                  op_use;
    logic [NUM_OPS-1:0][XLEN-1:0]        op_rf, op_data;
    logic [NUM_OPS-1:0][1:0]             op_sel;

    assign op_rs  = {r.rs2, r.rs1};
    assign op_use = {r.use_rs2, r.use_rs1};
    assign op_rf  = {r.rd2, r.rd1};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        id_ex_bypass_stage_bypass_mux u_mux (
            .rs           (op_rs[i]),
            .use_rs       (op_use[i]),
            .rf_data      (op_rf[i]),
            .mem_regwrite (mem_regwrite),
            .mem_rd       (mem_rd),
            .mem_result   (mem_result),
            .wb_regwrite  (wb_regwrite),
            .wb_rd        (wb_rd),
            .wb_wdata     (wb_wdata),
            .sel          (op_sel[i]),
            .data         (op_data[i])
        );
    end

    assign bus.ex_src1 = op_data[0];
    assign bus.ex_src2 = op_data[1];
    assign bus.ex_fwd1 = op_sel[0];
    assign bus.ex_fwd2 = op_sel[1];

endmodule

// File: tb/tb_id_ex_bypass_stage.sv
module tb_id_ex_bypass_stage;
    import id_ex_bypass_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_regwrite, wb_regwrite, hold, flush, load_use_stall;
    logic [RFIDX_WIDTH-1:0] mem_rd, wb_rd;
    logic [XLEN-1:0] mem_result, wb_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_bypass_stage_if bus ();

    id_ex_bypass_stage dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .hold(hold), .flush(flush), .load_use_stall(load_use_stall)
    );

    // Reference model of the EX slot contents.
    logic                   m_valid, m_u1, m_u2, m_rw, m_mr;
    logic [ADDR_SIZE-1:0]   m_pc;
    logic [RFIDX_WIDTH-1:0] m_rs1, m_rs2, m_rd;
    logic [XLEN-1:0]        m_rd1, m_rd2, m_imm;
    logic [CTRL_W-1:0]      m_ctrl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall();
        logic needs;
        needs = (bus.id_use_rs1 && bus.id_rs1 == m_rd) || (bus.id_use_rs2 && bus.id_rs2 == m_rd);
        return !flush && m_valid && m_mr && m_rd != 0 && bus.id_valid && needs;
    endfunction

    // Operand value a source should see: the youngest in-flight write to it.
    task automatic op_exp(input logic u, input logic [RFIDX_WIDTH-1:0] rs,
                          input logic [XLEN-1:0] rf,
                          output logic [1:0] s, output logic [XLEN-1:0] d);
        s = FWD_RF; d = rf;
        if (u && rs != 0) begin
            if (mem_regwrite && mem_rd == rs) begin s = FWD_MEM; d = mem_result; end
            else if (wb_regwrite && wb_rd == rs) begin s = FWD_WB; d = wb_wdata; end
        end
    endtask

    task automatic tick();
        logic st;
        st = model_stall();
        @(posedge clk);
        if (rst) begin
            {m_valid, m_u1, m_u2, m_rw, m_mr} = '0;
            m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_ctrl = '0;
        end else if (flush || (!hold && st)) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
        end else if (!hold) begin
            m_valid = bus.id_valid; m_pc = bus.id_pc;
            m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2;
            m_u1 = bus.id_use_rs1; m_u2 = bus.id_use_rs2; m_rd = bus.id_rd;
            m_rd1 = bus.id_rd1; m_rd2 = bus.id_rd2; m_imm = bus.id_imm;
            m_rw = bus.id_regwrite & bus.id_valid;
            m_mr = bus.id_memread & bus.id_valid;
            m_ctrl = bus.id_ctrl;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [1:0] s1, s2;
        logic [XLEN-1:0] d1, d2;
        #1;
        chk({tag, ".valid"}, 64'(bus.ex_valid), 64'(m_valid));
        chk({tag, ".regwrite"}, 64'(bus.ex_regwrite), 64'(m_rw));
        chk({tag, ".memread"}, 64'(bus.ex_memread), 64'(m_mr));
        chk({tag, ".stall"}, 64'(load_use_stall), 64'(model_stall()));
        if (m_valid) begin
            op_exp(m_u1, m_rs1, m_rd1, s1, d1);
            op_exp(m_u2, m_rs2, m_rd2, s2, d2);
            chk({tag, ".pc"}, 64'(bus.ex_pc), 64'(m_pc));
            chk({tag, ".rd"}, 64'(bus.ex_rd), 64'(m_rd));
            chk({tag, ".imm"}, 64'(bus.ex_imm), 64'(m_imm));
            chk({tag, ".ctrl"}, 64'(bus.ex_ctrl), 64'(m_ctrl));
            chk({tag, ".src1"}, 64'(bus.ex_src1), 64'(d1));
            chk({tag, ".src2"}, 64'(bus.ex_src2), 64'(d2));
            chk({tag, ".fwd1"}, 64'(bus.ex_fwd1), 64'(s1));
            chk({tag, ".fwd2"}, 64'(bus.ex_fwd2), 64'(s2));
        end
    endtask

    task automatic set_id(input logic [ADDR_SIZE-1:0] pc,
                          input logic [RFIDX_WIDTH-1:0] rs1, input logic u1,
                          input logic [RFIDX_WIDTH-1:0] rs2, input logic u2,
                          input logic [RFIDX_WIDTH-1:0] rd,
                          input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                          input logic [XLEN-1:0] imm, input logic rw, input logic mr);
        bus.id_valid = 1; bus.id_pc = pc;
        bus.id_rs1 = rs1; bus.id_use_rs1 = u1; bus.id_rs2 = rs2; bus.id_use_rs2 = u2;
        bus.id_rd = rd; bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm;
        bus.id_regwrite = rw; bus.id_memread = mr; bus.id_ctrl = pc[15:0];
    endtask

    task automatic no_fwd();
        mem_regwrite = 0; mem_rd = 0; mem_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_wdata = 0;
    endtask

    initial begin
        rst = 1; hold = 0; flush = 0; no_fwd();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.id_valid = 0;
        tick(); tick();
        rst = 0;
        #1;
        chk("reset.valid", 64'(bus.ex_valid), 0);
        chk("reset.pc", 64'(bus.ex_pc), 0);
        chk("reset.src1", 64'(bus.ex_src1), 0);
        chk("reset.src2", 64'(bus.ex_src2), 0);
        chk("reset.fwd1", 64'(bus.ex_fwd1), 64'(FWD_RF));
        chk("reset.rw", 64'(bus.ex_regwrite), 0);

        // MEM bypass: addi x5 ; add x6,x5,x5
        set_id(32'h100, 0, 1, 0, 0, 5, 0, 0, 1, 1, 0); tick();
        set_id(32'h104, 5, 1, 5, 1, 6, 0, 0, 0, 1, 0); tick();
        mem_regwrite = 1; mem_rd = 5; mem_result = 32'h10;
        check_all("mem_byp");
        chk("mem_byp.src1", 64'(bus.ex_src1), 64'h10);
        chk("mem_byp.src2", 64'(bus.ex_src2), 64'h10);
        chk("mem_byp.fwd1", 64'(bus.ex_fwd1), 64'(FWD_MEM));
        chk("mem_byp.fwd2", 64'(bus.ex_fwd2), 64'(FWD_MEM));

        // MEM over WB priority on rs1=7
        no_fwd();
        set_id(32'h108, 7, 1, 0, 0, 8, 32'h55, 0, 0, 1, 0); tick();
        mem_regwrite = 1; mem_rd = 7; mem_result = 32'hAA;
        wb_regwrite = 1; wb_rd = 7; wb_wdata = 32'hBB;
        check_all("prio");
        chk("prio.src1", 64'(bus.ex_src1), 64'hAA);
        chk("prio.fwd1", 64'(bus.ex_fwd1), 64'(FWD_MEM));
        mem_regwrite = 0;
        check_all("prio_wb");
        chk("prio_wb.src1", 64'(bus.ex_src1), 64'hBB);
        chk("prio_wb.fwd1", 64'(bus.ex_fwd1), 64'(FWD_WB));

        // x0 is never forwarded
        no_fwd();
        set_id(32'h10C, 0, 1, 0, 1, 9, 0, 0, 0, 1, 0); tick();
        mem_regwrite = 1; mem_rd = 0; mem_result = 32'hFFFF_FFFF;
        check_all("x0");
        chk("x0.src1", 64'(bus.ex_src1), 0);
        chk("x0.fwd1", 64'(bus.ex_fwd1), 64'(FWD_RF));

        // Load-use: lw x3 ; add x6,x3,x4
        no_fwd();
        set_id(32'h200, 1, 1, 0, 0, 3, 0, 0, 4, 1, 1); tick();
        set_id(32'h204, 3, 1, 4, 1, 6, 0, 32'h4, 0, 1, 0);
        #1 chk("lu.stall", 64'(load_use_stall), 1);
        tick();
        chk("lu.bubble_valid", 64'(bus.ex_valid), 0);
        chk("lu.bubble_rw", 64'(bus.ex_regwrite), 0);
        chk("lu.bubble_stall", 64'(load_use_stall), 0);
        wb_regwrite = 1; wb_rd = 3; wb_wdata = 32'h1234;
        tick();
        check_all("lu.add");
        chk("lu.add_pc", 64'(bus.ex_pc), 64'h204);
        chk("lu.add_src1", 64'(bus.ex_src1), 64'h1234);
        chk("lu.add_fwd1", 64'(bus.ex_fwd1), 64'(FWD_WB));

        // Same pair, but rs1 not actually read: no stall
        no_fwd();
        set_id(32'h210, 1, 1, 0, 0, 3, 0, 0, 4, 1, 1); tick();
        set_id(32'h214, 3, 0, 4, 1, 6, 0, 0, 0, 1, 0);
        #1 chk("lu_nouse.stall", 64'(load_use_stall), 0);
        tick();
        chk("lu_nouse.pc", 64'(bus.ex_pc), 64'h214);
        chk("lu_nouse.valid", 64'(bus.ex_valid), 1);

        // Hold for 3 cycles with decode changing
        set_id(32'h300, 0, 0, 0, 0, 1, 0, 0, 32'h33, 1, 0); tick();
        hold = 1;
        for (int k = 0; k < 3; k++) begin
            set_id(32'h400 + 4 * k, 0, 0, 0, 0, 2, 0, 0, k, 1, 0);
            tick();
            chk("hold.pc", 64'(bus.ex_pc), 64'h300);
            chk("hold.imm", 64'(bus.ex_imm), 64'h33);
        end
        hold = 0;
        tick();
        chk("hold_rel.pc", 64'(bus.ex_pc), 64'h408);
        chk("hold_rel.imm", 64'(bus.ex_imm), 64'h2);

        // Hold with load-use pending: hold wins, stall stays visible
        set_id(32'h320, 1, 1, 0, 0, 3, 0, 0, 0, 1, 1); tick();
        set_id(32'h324, 3, 1, 0, 0, 6, 0, 0, 0, 1, 0);
        hold = 1;
        #1 chk("hold_lu.stall", 64'(load_use_stall), 1);
        tick();
        chk("hold_lu.pc", 64'(bus.ex_pc), 64'h320);
        chk("hold_lu.valid", 64'(bus.ex_valid), 1);
        chk("hold_lu.stall2", 64'(load_use_stall), 1);
        hold = 0;

        // Reset mid-stream
        set_id(32'h500, 2, 1, 0, 0, 4, 32'h77, 0, 32'h9, 1, 0); tick();
        rst = 1; tick(); rst = 0;
        chk("rst_mid.valid", 64'(bus.ex_valid), 0);
        chk("rst_mid.pc", 64'(bus.ex_pc), 0);
        chk("rst_mid.imm", 64'(bus.ex_imm), 0);
        chk("rst_mid.src1", 64'(bus.ex_src1), 0);
        chk("rst_mid.rw", 64'(bus.ex_regwrite), 0);

        // Flush with load-use condition present
        set_id(32'h600, 1, 1, 0, 0, 3, 0, 0, 0, 1, 1); tick();
        set_id(32'h604, 3, 1, 0, 0, 6, 0, 0, 0, 1, 0);
        flush = 1; hold = 1;
        #1 chk("flush.stall", 64'(load_use_stall), 0);
        tick();
        chk("flush.valid", 64'(bus.ex_valid), 0);
        chk("flush.memread", 64'(bus.ex_memread), 0);
        flush = 0; hold = 0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            bus.id_valid = ($urandom_range(0, 5) != 0);
            bus.id_pc = $urandom; bus.id_imm = $urandom; bus.id_ctrl = 16'($urandom);
            bus.id_rs1 = 5'($urandom_range(0, 7)); bus.id_rs2 = 5'($urandom_range(0, 7));
            bus.id_use_rs1 = 1'($urandom); bus.id_use_rs2 = 1'($urandom);
            bus.id_rd = 5'($urandom_range(0, 7));
            bus.id_rd1 = $urandom; bus.id_rd2 = $urandom;
            bus.id_regwrite = 1'($urandom); bus.id_memread = 1'($urandom);
            mem_regwrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
            wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
            check_all("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
